// File: rtl/wb_project_mux_pkg.sv
// wb_project_mux_pkg: shared types and constants for the Wishbone project mux
package wb_project_mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RESP
    } state_t;

    localparam logic [3:0]  LOCAL_SLOT     = 4'hF;
    localparam logic [1:0]  REG_STATUS     = 2'd0;
    localparam logic [1:0]  REG_ERR_ADR    = 2'd1;
    localparam logic [31:0] ERR_DATA_DEF   = 32'hDEADBEEF;
    localparam logic [31:0] UNMAP_DATA_DEF = 32'hBADADD00;

endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: clearable wait counter with terminal count and saturating 16-bit error counter
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        err_inc,
    input  logic        err_clr,
    output logic        tc,
    output logic [15:0] err_cnt
);

    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= clr ? '0 : en ? cnt + W'(1) : cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                             err_cnt <= '0;
        else if (err_clr)                       err_cnt <= '0;
        else if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;

    assign tc = cnt == W'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/wb_project_mux.sv
// wb_project_mux: registered Wishbone decoder and one-hot response mux for per-project slaves
module wb_project_mux
    import wb_project_mux_pkg::*;
#(
    parameter int          NUM_SLAVES     = 8,
    parameter logic [7:0]  BASE_HI        = 8'h30,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF,
    parameter logic [31:0] UNMAP_DATA     = UNMAP_DATA_DEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic [NUM_SLAVES-1:0]    active,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [3:0]               s_sel_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i,
    output logic                     err_irq_o
);

    state_t                  state, nxt;
    logic [NUM_SLAVES-1:0]   req_oh, sel_oh;
    logic [31:0]             resp_dat, last_err_adr, local_rd, rd_sel;
    logic [15:0]             err_cnt;
    logic [3:0]              slot;
    logic [1:0]              idx;
    logic                    req, hit, is_local, is_valid, accept, ack_sel, tc;
    logic                    fwd_done, timeout, local_clr, unmapped, err_sticky;

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign hit       = wbs_adr_i[31:24] == BASE_HI;
    assign slot      = wbs_adr_i[23:20];
    assign idx       = wbs_adr_i[3:2];
    assign is_local  = hit && slot == LOCAL_SLOT;
    assign is_valid  = |req_oh;
    assign accept    = state == IDLE && req;
    assign ack_sel   = |(s_ack_i & sel_oh);
    assign fwd_done  = state == FWD && wbs_cyc_i && ack_sel;
    assign timeout   = state == FWD && wbs_cyc_i && !ack_sel && tc;
    assign local_clr = accept && is_local && wbs_we_i && idx == REG_STATUS && wbs_dat_i[31];
    assign unmapped  = accept && !is_local && !is_valid;
    assign err_irq_o = err_sticky;

    // One-hot decode avoids indexing narrow vectors with the 4-bit slot field
    always_comb begin
        req_oh = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            req_oh[i] = hit && slot == 4'(i) && active[i];
            rd_sel    = rd_sel | (sel_oh[i] ? s_dat_i[32*i +: 32] : 32'h0);
        end
    end

    always_comb begin
        local_rd = idx == REG_STATUS  ? {err_sticky, 15'b0, err_cnt} :
                   idx == REG_ERR_ADR ? last_err_adr : 32'h0;
    end

    wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clr     (accept),
        .en      (state == FWD),
        .err_inc (timeout),
        .err_clr (local_clr),
        .tc      (tc),
        .err_cnt (err_cnt)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) state <= IDLE;
        else            state <= nxt;

    // Master abort takes priority; a same-cycle ack beats the timeout
    always_comb begin
        nxt = state == IDLE ? (!req ? IDLE : is_valid ? FWD : RESP) :
              state == FWD  ? (!wbs_cyc_i ? IDLE : (ack_sel || tc) ? RESP : FWD) :
              IDLE;
    end

    always_comb begin
        wbs_ack_o = state == RESP;
        wbs_dat_o = state == RESP ? resp_dat : 32'h0;
        s_cyc_o   = state == FWD ? sel_oh : '0;
        s_stb_o   = state == FWD ? sel_oh : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            s_we_o       <= 1'b0;
            s_sel_o      <= '0;
            s_adr_o      <= '0;
            s_dat_o      <= '0;
            sel_oh       <= '0;
            resp_dat     <= '0;
            err_sticky   <= 1'b0;
            last_err_adr <= '0;
        end else begin
            if (accept) begin
                s_we_o   <= wbs_we_i;
                s_sel_o  <= wbs_sel_i;
                s_adr_o  <= wbs_adr_i;
                s_dat_o  <= wbs_dat_i;
                sel_oh   <= req_oh;
                resp_dat <= is_local ? (wbs_we_i ? 32'h0 : local_rd) : is_valid ? 32'h0 : UNMAP_DATA;
            end
            if (local_clr) err_sticky <= 1'b0;
            if (unmapped) begin
                err_sticky   <= 1'b1;
                last_err_adr <= wbs_adr_i;
            end
            if (fwd_done) resp_dat <= s_we_o ? 32'h0 : rd_sel;
            if (timeout) begin
                resp_dat     <= ERR_DATA;
                err_sticky   <= 1'b1;
                last_err_adr <= s_adr_o;
            end
        end

endmodule
